// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: serves 32-bit words on a hit with no stall,
// and on a miss refills one 128-bit line over the instruction memory's READ/BUSYWAIT handshake.
module instruction_cache #(
    parameter int NUM_SETS = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CPU_READ,
    input  logic [31:0]  PC_ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         CPU_BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int INDEX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS   = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FETCH, INSTALL} state_t;

    state_t state, state_next;

    logic [NUM_SETS-1:0] valid;
    logic [TAG_BITS-1:0] tag_arr  [NUM_SETS];
    logic [127:0]        data_arr [NUM_SETS];

    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] fetch_index;

    logic [1:0]            pc_word;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  hit;
    logic [31:0]           hit_word;
    logic                  miss_start;
    logic                  fill_en;
    logic                  pc_unused;

    assign pc_word   = PC_ADDRESS[3:2];
    assign pc_index  = PC_ADDRESS[4 +: INDEX_BITS];
    assign pc_tag    = PC_ADDRESS[31:4+INDEX_BITS];
    assign pc_unused = ^PC_ADDRESS[1:0];

    assign hit        = CPU_READ & valid[pc_index] & (tag_arr[pc_index] == pc_tag);
    assign hit_word   = data_arr[pc_index][{pc_word, 5'b00000} +: 32];
    assign miss_start = (state == IDLE) & CPU_READ & ~hit;
    assign fill_en    = (state == FETCH) & ~MEM_BUSYWAIT;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            valid       <= '0;
            MEM_READ    <= 1'b0;
            MEM_ADDRESS <= '0;
        end else begin
            state <= state_next;
            if (miss_start) begin
                MEM_READ    <= 1'b1;
                MEM_ADDRESS <= PC_ADDRESS[31:4];
                fetch_tag   <= pc_tag;
                fetch_index <= pc_index;
            end else if (fill_en) begin
                MEM_READ           <= 1'b0;
                valid[fetch_index] <= 1'b1;
            end
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone make stale
    // contents unobservable, which keeps the arrays mappable to plain RAM.
    always_ff @(posedge CLK) begin
        if (!RESET && fill_en) begin
            tag_arr[fetch_index]  <= fetch_tag;
            data_arr[fetch_index] <= MEM_READDATA;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next   = state;
        CPU_BUSYWAIT = 1'b1;
        INSTRUCTION  = '0;
        case (state)
            IDLE: begin
                CPU_BUSYWAIT = CPU_READ & ~hit;
                if (hit) begin
                    INSTRUCTION = hit_word;
                end
                if (CPU_READ && !hit) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (!MEM_BUSYWAIT) begin
                    state_next = INSTALL;
                end
            end
            INSTALL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Reset dominates: the CPU is held off until the cache is usable.
        if (RESET) begin
            CPU_BUSYWAIT = 1'b1;
            INSTRUCTION  = '0;
        end
    end

endmodule
